otter_fetch_queue: RTL and testbench
====================================

Name: otter_fetch_queue

Overview:
Instruction-fetch front end for the pipelined OTTER core. It drives the instruction port of the byte memory (one-cycle synchronous read) and captures each returned word with its PC in a small prefetch FIFO. It presents instructions to the decode-stage registers through a valid/ready handshake. A redirect from the decode-stage branch/jump logic flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; asynchronous assert, active-low (0 = reset)
MEM_ADDR1  out  32  instruction fetch address
MEM_READ1  out  1  fetch request this cycle
MEM_DOUT1  in  32  instruction word, valid the cycle after a request
REDIRECT  in  1  flush and restart fetch
REDIRECT_PC  in  32  restart target
DEC_READY  in  1  decode accepts head entry (low = stall)
DEC_VALID  out  1  head entry valid
DEC_IR  out  32  head instruction; NOP when DEC_VALID=0
DEC_PC  out  32  head PC; 0 when DEC_VALID=0
COUNT  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (RST=0, no clock needed): state=ST_BOOT, fetch_pc=RESET_PC, COUNT=0, inflight=0, DEC_VALID=0, DEC_IR=32'h00000013, DEC_PC=0, MEM_READ1=0, MEM_ADDR1=RESET_PC.
- FSM states:
  - ST_BOOT: one cycle after reset release, no request issued. Goes to ST_RUN unconditionally.
  - ST_RUN: normal operation.
- MEM_ADDR1 = fetch_pc at all times.
- Issue (ST_RUN): MEM_READ1 = (COUNT + inflight < DEPTH) and not REDIRECT.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32; wraps 0xFFFFFFFC -> 0x0).
  - Otherwise inflight<=0.
- Capture: in the cycle after an issue (inflight=1, no REDIRECT), {inflight_pc, MEM_DOUT1} is pushed at the clock edge.
  - Credit rule guarantees a push never overflows.
- Pop: when DEC_VALID and DEC_READY, the head is dequeued at the edge. Push and pop in the same cycle leave COUNT unchanged.
- DEC_VALID = (COUNT != 0); DEC_IR/DEC_PC are combinational from the head entry.
- Latency: request in cycle c -> push at end of c+1 -> DEC_VALID in c+2.
- Throughput: 1 instr/cycle sustained with DEC_READY=1.
- REDIRECT sampled high in cycle t (overrides everything):
  - FIFO cleared: COUNT=0 and pointers reset at the edge.
  - inflight<=0; any response returning in t+1 is discarded.
  - fetch_pc <= {REDIRECT_PC[31:2], 2'b00}; misaligned targets are force-aligned.
  - MEM_READ1=0 in t; target issued in t+1, DEC_VALID with the target in t+3.
  - A pop handshake in t still counts as accepted by decode.
  - REDIRECT in ST_BOOT loads fetch_pc; ST_RUN follows as usual.
- Full (COUNT=DEPTH, DEC_READY=0): no issue, contents held stable, DEC_IR/DEC_PC unchanged.
- Empty with DEC_READY=1: no pop, DEC_VALID=0.
- Reset asserted mid-operation: all state returns to reset values immediately; the in-flight response is ignored after release.

Decomposition:
- Package otter_fetch_pkg:
  - OTTER_NOP = 32'h00000013
  - fetch_state_t enum {ST_BOOT, ST_RUN}
  - fq_entry_t packed struct {pc[31:0], ir[31:0]}
- Sub-module otter_fetch_fifo: DEPTH-entry storage of fq_entry_t with wrapping read/write pointers, count, push/pop/clear inputs, and the same CLK/RST.
- Top level holds the FSM, fetch_pc, the inflight tracking and the credit logic.

Test Plan:
- Boot: release reset, DEC_READY=1, memory returns word = addr ^ 0xA5A5A5A5 -> MEM_READ1 first high in cycle 1 at addr 0; DEC_VALID first in cycle 3 with DEC_PC=0, DEC_IR=0xA5A5A5A5; then PCs 4, 8, 12 on consecutive cycles.
- Backpressure: hold DEC_READY=0 from boot -> COUNT saturates at 4, MEM_READ1 stays low, head held at PC 0; release -> PCs 0, 4, 8, 12, 16 in order with no duplicates or gaps.
- Redirect: with COUNT=3 and a request in flight, pulse REDIRECT with 0x100 -> COUNT=0 next cycle, the stale response is never presented, and DEC_PC=0x100 appears exactly 3 cycles after the pulse.
- Alignment and wrap: REDIRECT_PC=0xFFFFFFFF -> presented PCs are 0xFFFFFFFC, then 0x00000000, then 0x00000004.
- Simultaneous: REDIRECT, DEC_READY and a push in the same cycle -> queue empty afterwards, and the next presented entry is the target PC.
- Async reset: assert RST=0 mid-stream with COUNT=2 and no clock edge -> DEC_VALID=0, DEC_IR=0x00000013, COUNT=0, MEM_ADDR1=RESET_PC immediately; after release the boot sequence repeats.

Source files
------------

// File: rtl/otter_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otter_fetch_pkg
// Description : Shared types and constants for the OTTER fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package otter_fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) presented when the queue is empty
    localparam logic [31:0] OTTER_NOP = 32'h00000013;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fq_entry_t;

endpackage : otter_fetch_pkg
`default_nettype wire

// File: rtl/otter_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : otter_fetch_fifo
// Description : DEPTH-entry prefetch FIFO of {pc, ir} pairs with wrapping
//               pointers, occupancy count and a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_fifo
    import otter_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          clear,
    output fq_entry_t     head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Clear dominates; a pop on an empty queue is ignored
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (count != '0);
    assign head    = mem[rd_ptr];

    // Entry storage; no reset needed since empty slots are never presented
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : otter_fetch_fifo
`default_nettype wire

// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : otter_fetch_queue
// Description : OTTER instruction-fetch front end. Issues sequential fetches
//               to a one-cycle synchronous memory, buffers responses in a
//               prefetch FIFO and hands them to decode via valid/ready.
//               A redirect flushes the queue and restarts at the target.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_queue
    import otter_fetch_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = 32'h00000000,
    localparam int          CW       = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    output logic [31:0]   MEM_ADDR1,
    output logic          MEM_READ1,
    input  logic [31:0]   MEM_DOUT1,
    input  logic          REDIRECT,
    input  logic [31:0]   REDIRECT_PC,
    input  logic          DEC_READY,
    output logic          DEC_VALID,
    output logic [31:0]   DEC_IR,
    output logic [31:0]   DEC_PC,
    output logic [CW-1:0] COUNT
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic [CW:0]  occupancy;
    logic         issue;
    logic         push;
    logic         pop;
    fq_entry_t    push_entry;
    fq_entry_t    head;
    logic         unused_redirect_lsbs;

    // Low target bits are discarded by force-alignment
    assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

    // Credit: queued entries plus the outstanding request must leave a free slot
    assign occupancy = {1'b0, COUNT} + {{CW{1'b0}}, inflight};
    assign issue     = (state == ST_RUN) && (occupancy < (CW + 1)'(DEPTH)) && !REDIRECT;

    assign MEM_ADDR1 = fetch_pc;
    assign MEM_READ1 = issue;

    // A response returning under a redirect belongs to the abandoned stream
    assign push       = inflight && !REDIRECT;
    assign push_entry = '{pc: inflight_pc, ir: MEM_DOUT1};
    assign pop        = DEC_VALID && DEC_READY;

    assign DEC_VALID = (COUNT != '0);
    assign DEC_IR    = DEC_VALID ? head.ir : OTTER_NOP;
    assign DEC_PC    = DEC_VALID ? head.pc : 32'h0;

    // Fetch FSM, PC sequencing and in-flight request tracking
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_BOOT;
            endcase
            if (REDIRECT) begin
                fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
                inflight <= 1'b0;
            end else if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    otter_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (REDIRECT),
        .head      (head),
        .count     (COUNT)
    );

endmodule : otter_fetch_queue
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_fetch_queue
// Description : Directed self-checking bench for otter_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK;
    logic        RST;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DEC_READY;
    logic        DEC_VALID;
    logic [31:0] DEC_IR;
    logic [31:0] DEC_PC;
    logic [2:0]  COUNT;

    int n_cmp;
    int n_bad;

    otter_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h00000000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .MEM_ADDR1   (MEM_ADDR1),
        .MEM_READ1   (MEM_READ1),
        .MEM_DOUT1   (MEM_DOUT1),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .DEC_READY   (DEC_READY),
        .DEC_VALID   (DEC_VALID),
        .DEC_IR      (DEC_IR),
        .DEC_PC      (DEC_PC),
        .COUNT       (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle synchronous instruction memory: word = addr ^ KEY
    always @(posedge CLK) begin
        MEM_DOUT1 <= MEM_READ1 ? (MEM_ADDR1 ^ KEY) : 32'hDEADBEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Assert reset away from any edge, check reset values, release after an edge.
    // On return the bench sits in cycle 0 (ST_BOOT).
    task automatic do_reset(input logic ready);
        RST       = 1'b0;
        DEC_READY = ready;
        REDIRECT  = 1'b0;
        #1;
        check("rst_valid", 32'(DEC_VALID), 32'd0);
        check("rst_ir",    DEC_IR,         NOP);
        check("rst_pc",    DEC_PC,         32'd0);
        check("rst_count", 32'(COUNT),     32'd0);
        check("rst_read",  32'(MEM_READ1), 32'd0);
        check("rst_addr",  MEM_ADDR1,      32'd0);
        step();
        RST = 1'b1;
    endtask

    initial begin
        RST         = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        DEC_READY   = 1'b1;
        n_cmp       = 0;
        n_bad       = 0;
        #2;

        // ---------------- Boot ----------------
        do_reset(1'b1);
        check("boot_c0_read", 32'(MEM_READ1), 32'd0);
        step();
        check("boot_c1_read", 32'(MEM_READ1), 32'd1);
        check("boot_c1_addr", MEM_ADDR1,      32'd0);
        step();
        check("boot_c2_valid", 32'(DEC_VALID), 32'd0);
        step();
        check("boot_c3_valid", 32'(DEC_VALID), 32'd1);
        check("boot_c3_pc",    DEC_PC,         32'd0);
        check("boot_c3_ir",    DEC_IR,         KEY);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("boot_seq_pc", DEC_PC, 32'(4 * i));
            check("boot_seq_ir", DEC_IR, 32'(4 * i) ^ KEY);
        end

        // ---------------- Backpressure ----------------
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step();   // cycle 6
        check("bp_count_full", 32'(COUNT),     32'd4);
        check("bp_read_low",   32'(MEM_READ1), 32'd0);
        check("bp_head_pc",    DEC_PC,         32'd0);
        step();                                // cycle 7
        check("bp_hold_count", 32'(COUNT),     32'd4);
        check("bp_hold_pc",    DEC_PC,         32'd0);
        check("bp_hold_read",  32'(MEM_READ1), 32'd0);
        step();                                // cycle 8
        DEC_READY = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_pc", DEC_PC, 32'(4 * i));
            step();
        end

        // ---------------- Redirect with request in flight ----------------
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();   // cycle 5: COUNT=3, response returning
        check("rd_pre_count", 32'(COUNT), 32'd3);
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h00000100;
        #1;
        check("rd_t_read", 32'(MEM_READ1), 32'd0);
        step();                                // t+1
        REDIRECT = 1'b0;
        #1;
        check("rd_t1_count", 32'(COUNT),     32'd0);
        check("rd_t1_read",  32'(MEM_READ1), 32'd1);
        check("rd_t1_addr",  MEM_ADDR1,      32'h00000100);
        step();                                // t+2
        check("rd_t2_valid", 32'(DEC_VALID), 32'd0);
        step();                                // t+3
        check("rd_t3_valid", 32'(DEC_VALID), 32'd1);
        check("rd_t3_pc",    DEC_PC,         32'h00000100);
        check("rd_t3_ir",    DEC_IR,         32'h00000100 ^ KEY);
        DEC_READY = 1'b1;
        step();                                // t+4
        check("rd_t4_pc", DEC_PC, 32'h00000104);

        // ---------------- Alignment and wrap ----------------
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'hFFFFFFFF;
        #1;
        check("wr_u_read", 32'(MEM_READ1), 32'd0);
        step();                                // u+1
        REDIRECT = 1'b0;
        #1;
        check("wr_u1_addr", MEM_ADDR1, 32'hFFFFFFFC);
        step();                                // u+2
        check("wr_u2_valid", 32'(DEC_VALID), 32'd0);
        step();                                // u+3
        check("wr_pc0", DEC_PC, 32'hFFFFFFFC);
        step();
        check("wr_pc1", DEC_PC, 32'h00000000);
        step();
        check("wr_pc2", DEC_PC, 32'h00000004);
        step();                                // steady streaming

        // ---------------- Redirect + pop + push in one cycle ----------------
        check("sim_pre_valid", 32'(DEC_VALID), 32'd1);
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h00000200;
        step();
        REDIRECT = 1'b0;
        #1;
        check("sim_count",  32'(COUNT),     32'd0);
        check("sim_valid1", 32'(DEC_VALID), 32'd0);
        step();
        check("sim_valid2", 32'(DEC_VALID), 32'd0);
        step();
        check("sim_valid3", 32'(DEC_VALID), 32'd1);
        check("sim_pc",     DEC_PC,         32'h00000200);

        // ---------------- Async reset mid-stream ----------------
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step();   // cycle 4: COUNT=2
        check("ar_pre_count", 32'(COUNT), 32'd2);
        DEC_READY = 1'b1;
        do_reset(1'b1);                        // checks immediate reset values
        step();
        check("ar_c1_read", 32'(MEM_READ1), 32'd1);
        check("ar_c1_addr", MEM_ADDR1,      32'd0);
        step();
        check("ar_c2_valid", 32'(DEC_VALID), 32'd0);
        step();
        check("ar_c3_pc", DEC_PC, 32'd0);
        check("ar_c3_ir", DEC_IR, KEY);
        step();
        check("ar_c4_pc", DEC_PC, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_otter_fetch_queue
`default_nettype wire
